// File: rtl/rx_iq_fifo_pkg.sv
// rx_iq_fifo_pkg: shared IQ width, frame type and pointer-width helper for the RX IQ FIFO.
package rx_iq_fifo_pkg;
    localparam int IQ_DW = 24;
    typedef struct packed {
        logic signed [IQ_DW-1:0] rx1_i;
        logic signed [IQ_DW-1:0] rx1_q;
        logic signed [IQ_DW-1:0] rx2_i;
        logic signed [IQ_DW-1:0] rx2_q;
    } iq_frame_t;
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/iq_sdp_ram.sv
// iq_sdp_ram: simple dual-port RAM, one write port and one registered read port, no array reset.
module iq_sdp_ram #(
    parameter int AW = 8,
    parameter int W  = 96
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);
    logic [W-1:0] r_mem [2**AW];
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/rx_iq_fifo.sv
// rx_iq_fifo: circular buffer of {RX1_I, RX1_Q, RX2_I, RX2_Q} frames with a first-word-fall-through
// prefetch head, sticky overrun/underrun flags and a synchronous flush.
module rx_iq_fifo
    import rx_iq_fifo_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int DW    = IQ_DW
) (
    input  logic                      clk_in,
    input  logic                      reset_n,
    input  logic signed [DW-1:0]      rx1_i,
    input  logic signed [DW-1:0]      rx1_q,
    input  logic signed [DW-1:0]      rx2_i,
    input  logic signed [DW-1:0]      rx2_q,
    input  logic                      rx_valid,
    input  logic                      rd_en,
    input  logic                      flush,
    input  logic                      flag_clear,
    output logic signed [DW-1:0]      out_rx1_i,
    output logic signed [DW-1:0]      out_rx1_q,
    output logic signed [DW-1:0]      out_rx2_i,
    output logic signed [DW-1:0]      out_rx2_q,
    output logic                      empty,
    output logic                      full,
    output logic [ptr_w(DEPTH)-1:0]   level,
    output logic                      overrun,
    output logic                      underrun
);
    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;
    localparam int FW = 4 * DW;

    logic [PW-1:0] r_wptr, r_rptr, w_rptr_nxt, w_level;
    logic [FW-1:0] r_pref, w_rdata;
    logic          r_rd_ok, r_valid, r_ovr, r_und;
    logic          w_full, w_we, w_pop;

    assign w_level    = r_wptr - r_rptr;
    assign w_full     = w_level == PW'(DEPTH);
    assign w_we       = rx_valid && !w_full && !flush;
    assign w_pop      = rd_en && r_valid && (r_rptr != r_wptr) && !flush;
    // The RAM reads the post-pop head address so the next head reaches the prefetch one edge after a pop.
    assign w_rptr_nxt = r_rptr + {{(PW-1){1'b0}}, w_pop};

    iq_sdp_ram #(.AW(AW), .W(FW)) u_ram (
        .i_clk   (clk_in),
        .i_we    (w_we),
        .i_waddr (r_wptr[AW-1:0]),
        .i_wdata ({rx1_i, rx1_q, rx2_i, rx2_q}),
        .i_raddr (w_rptr_nxt[AW-1:0]),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_rd_ok <= 1'b0;
            r_valid <= 1'b0;
            r_pref  <= '0;
            r_ovr   <= 1'b0;
            r_und   <= 1'b0;
        end else begin
            r_ovr <= (rx_valid && w_full && !flush) || (r_ovr && !flag_clear);
            r_und <= (rd_en && !r_valid && !flush) || (r_und && !flag_clear);
            if (flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_rd_ok <= 1'b0;
                r_valid <= 1'b0;
                r_pref  <= '0;
            end else begin
                r_wptr  <= r_wptr + {{(PW-1){1'b0}}, w_we};
                r_rptr  <= w_rptr_nxt;
                // Read data is only trusted if its slot was written before this edge.
                r_rd_ok <= r_wptr != w_rptr_nxt;
                r_valid <= r_rd_ok;
                if (r_rd_ok) r_pref <= w_rdata;
            end
        end
    end

    assign {out_rx1_i, out_rx1_q, out_rx2_i, out_rx2_q} = r_pref;
    assign empty    = !r_valid;
    assign full     = w_full;
    assign level    = w_level;
    assign overrun  = r_ovr;
    assign underrun = r_und;
endmodule

// File: tb/tb_rx_iq_fifo.sv
// tb_rx_iq_fifo: randomized scenarios checked against a queue-based model of the RX IQ FIFO.
module tb_rx_iq_fifo;
    import rx_iq_fifo_pkg::*;
    localparam int DEPTH = 16;
    localparam int LW = $clog2(DEPTH) + 1;

    logic clk_in = 1'b0, reset_n = 1'b0;
    logic signed [IQ_DW-1:0] rx1_i, rx1_q, rx2_i, rx2_q;
    logic signed [IQ_DW-1:0] out_rx1_i, out_rx1_q, out_rx2_i, out_rx2_q;
    logic rx_valid = 0, rd_en = 0, flush = 0, flag_clear = 0;
    logic empty, full, overrun, underrun;
    logic [LW-1:0] level;
    iq_frame_t dut_f;

    iq_frame_t q[$];
    iq_frame_t last;
    logic m_ovr, m_und;
    int n_cmp = 0, n_err = 0;

    rx_iq_fifo #(.DEPTH(DEPTH), .DW(IQ_DW)) dut (
        .clk_in(clk_in), .reset_n(reset_n),
        .rx1_i(rx1_i), .rx1_q(rx1_q), .rx2_i(rx2_i), .rx2_q(rx2_q),
        .rx_valid(rx_valid), .rd_en(rd_en), .flush(flush), .flag_clear(flag_clear),
        .out_rx1_i(out_rx1_i), .out_rx1_q(out_rx1_q), .out_rx2_i(out_rx2_i), .out_rx2_q(out_rx2_q),
        .empty(empty), .full(full), .level(level), .overrun(overrun), .underrun(underrun)
    );

    always #5 clk_in = ~clk_in;
    assign dut_f = {out_rx1_i, out_rx1_q, out_rx2_i, out_rx2_q};

    function automatic iq_frame_t rnd();
        iq_frame_t f;
        f.rx1_i = IQ_DW'($urandom);
        f.rx1_q = IQ_DW'($urandom);
        f.rx2_i = IQ_DW'($urandom);
        f.rx2_q = IQ_DW'($urandom);
        return f;
    endfunction

    function automatic iq_frame_t m_head();
        return (q.size() != 0) ? q[0] : last;
    endfunction

    // Drive one cycle of inputs, advance the model by the same edge, then idle the inputs.
    task automatic step(input logic v, r, f, fc, input iq_frame_t d);
        logic full0, emp0;
        {rx1_i, rx1_q, rx2_i, rx2_q} = d;
        rx_valid = v; rd_en = r; flush = f; flag_clear = fc;
        @(posedge clk_in); #1;
        full0 = q.size() == DEPTH;
        emp0  = q.size() == 0;
        if (f) begin
            q.delete();
            last = '0;
        end else begin
            if (r && !emp0) last = q.pop_front();
            if (v && !full0) q.push_back(d);
        end
        m_ovr = (v && full0 && !f) ? 1'b1 : (fc ? 1'b0 : m_ovr);
        m_und = (r && emp0 && !f) ? 1'b1 : (fc ? 1'b0 : m_und);
        rx_valid = 0; rd_en = 0; flush = 0; flag_clear = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0);
    endtask

    task automatic test_reset();
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b exp 1", empty); end
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b exp 0", full); end
        n_cmp++; if (level !== '0) begin n_err++; $display("FAIL reset_level got %0d exp 0", level); end
        n_cmp++; if (overrun !== 1'b0 || underrun !== 1'b0) begin n_err++; $display("FAIL reset_flags got %b%b exp 00", overrun, underrun); end
        n_cmp++; if (dut_f !== '0) begin n_err++; $display("FAIL reset_data got %h exp 0", dut_f); end
    endtask

    // Pop every frame with wide spacing, checking the head before each pop.
    task automatic drain(input string tag);
        while (q.size() != 0) begin
            n_cmp++; if (dut_f !== q[0]) begin n_err++; $display("FAIL %s_head got %h exp %h", tag, dut_f, q[0]); end
            step(0, 1, 0, 0, '0);
            n_cmp++; if (level !== LW'(q.size())) begin n_err++; $display("FAIL %s_level got %0d exp %0d", tag, level, q.size()); end
            idle(5);
        end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL %s_empty got %b exp 1", tag, empty); end
        n_cmp++; if (dut_f !== last) begin n_err++; $display("FAIL %s_hold got %h exp %h", tag, dut_f, last); end
    endtask

    task automatic test_order();
        iq_frame_t d;
        for (int i = 1; i <= 3; i++) begin
            d = rnd(); d.rx1_i = IQ_DW'(i);
            step(1, 0, 0, 0, d);
            n_cmp++; if (empty !== (i < 3)) begin n_err++; $display("FAIL order_latency%0d got %b exp %b", i, empty, i < 3); end
        end
        n_cmp++; if (out_rx1_i !== 24'sd1) begin n_err++; $display("FAIL order_first got %0d exp 1", out_rx1_i); end
        idle(2);
        n_cmp++; if (level !== LW'(3)) begin n_err++; $display("FAIL order_level got %0d exp 3", level); end
        for (int i = 1; i <= 3; i++) begin
            n_cmp++; if (out_rx1_i !== IQ_DW'(i) || dut_f !== q[0]) begin n_err++; $display("FAIL order_pop%0d got %h exp %h", i, dut_f, q[0]); end
            step(0, 1, 0, 0, '0);
            idle(1);
            n_cmp++; if (level !== LW'(3 - i)) begin n_err++; $display("FAIL order_level%0d got %0d exp %0d", i, level, 3 - i); end
            n_cmp++; if (empty !== (i == 3)) begin n_err++; $display("FAIL order_empty%0d got %b exp %b", i, empty, i == 3); end
            idle(4);
        end
    endtask

    task automatic test_overrun();
        for (int i = 0; i <= DEPTH; i++) begin
            step(1, 0, 0, 0, rnd());
            if (i == DEPTH - 1) begin
                n_cmp++; if (full !== 1'b1 || overrun !== 1'b0) begin n_err++; $display("FAIL ovr_full got %b%b exp 10", full, overrun); end
            end
        end
        n_cmp++; if (overrun !== m_ovr || level !== LW'(DEPTH)) begin n_err++; $display("FAIL ovr_flag got %b/%0d exp %b/%0d", overrun, level, m_ovr, DEPTH); end
        idle(2);
        drain("ovr");
        step(0, 0, 0, 1, '0);
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clear got %b exp 0", overrun); end
    endtask

    task automatic test_underrun();
        iq_frame_t h;
        h = m_head();
        step(0, 1, 0, 0, '0);
        n_cmp++; if (underrun !== m_und || m_und !== 1'b1) begin n_err++; $display("FAIL und_set got %b exp 1", underrun); end
        idle(2);
        n_cmp++; if (dut_f !== h) begin n_err++; $display("FAIL und_hold got %h exp %h", dut_f, h); end
        step(0, 1, 0, 1, '0);
        n_cmp++; if (underrun !== 1'b1) begin n_err++; $display("FAIL und_setwins got %b exp 1", underrun); end
        step(0, 0, 0, 1, '0);
        n_cmp++; if (underrun !== m_und) begin n_err++; $display("FAIL und_clear got %b exp %b", underrun, m_und); end
    endtask

    task automatic test_full_rw();
        iq_frame_t d;
        for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0, rnd());
        idle(2);
        d = rnd();
        step(1, 1, 0, 0, d);
        n_cmp++; if (level !== LW'(q.size()) || q.size() != DEPTH - 1) begin n_err++; $display("FAIL fullrw_level got %0d exp %0d", level, DEPTH - 1); end
        n_cmp++; if (overrun !== 1'b1 || full !== 1'b0) begin n_err++; $display("FAIL fullrw_flags got ovr=%b full=%b exp ovr=1 full=0", overrun, full); end
        idle(2);
        drain("fullrw");
        step(0, 0, 0, 1, '0);
    endtask

    task automatic test_flush();
        step(0, 1, 0, 0, '0);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, rnd());
        idle(2);
        step(1, 0, 1, 0, rnd());
        n_cmp++; if (level !== '0 || empty !== 1'b1) begin n_err++; $display("FAIL flush_clear got level=%0d empty=%b exp level=0 empty=1", level, empty); end
        n_cmp++; if (underrun !== m_und || overrun !== m_ovr) begin n_err++; $display("FAIL flush_flags got %b%b exp %b%b", overrun, underrun, m_ovr, m_und); end
        idle(3);
        n_cmp++; if (empty !== 1'b1 || level !== '0 || dut_f !== '0) begin n_err++; $display("FAIL flush_nostore got empty=%b level=%0d data=%h", empty, level, dut_f); end
        step(0, 0, 0, 1, '0);
    endtask

    task automatic test_stream();
        for (int i = 0; i < DEPTH / 2; i++) step(1, 0, 0, 0, rnd());
        idle(2);
        for (int i = 0; i < 3 * DEPTH; i++) begin
            n_cmp++; if (dut_f !== q[0]) begin n_err++; $display("FAIL stream_%0d got %h exp %h", i, dut_f, q[0]); end
            step(1, 1, 0, 0, rnd());
            idle(5);
        end
        n_cmp++; if (overrun !== 1'b0 || level !== LW'(q.size())) begin n_err++; $display("FAIL stream_end got ovr=%b level=%0d exp ovr=0 level=%0d", overrun, level, q.size()); end
        step(1, 0, 0, 0, rnd());
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (empty !== 1'b1 || full !== 1'b0 || level !== '0 || dut_f !== '0 || overrun !== 1'b0 || underrun !== 1'b0)
            begin n_err++; $display("FAIL async_reset got empty=%b full=%b level=%0d data=%h", empty, full, level, dut_f); end
        q.delete(); last = '0; m_ovr = 0; m_und = 0;
        @(negedge clk_in); reset_n = 1'b1;
        idle(3);
        n_cmp++; if (empty !== 1'b1 || level !== '0) begin n_err++; $display("FAIL post_reset got empty=%b level=%0d", empty, level); end
    endtask

    initial begin
        {rx1_i, rx1_q, rx2_i, rx2_q} = '0;
        last = '0; m_ovr = 0; m_und = 0;
        #22 reset_n = 1'b1;
        test_reset();
        test_order();
        test_overrun();
        test_underrun();
        test_full_rw();
        test_flush();
        test_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
